dice_roll_sequencer: RTL and testbench

Controller that sequences a die roll for the dice-roller datapath. It debounces the roll button, latches the die type and runs a timed "tumbling" animation. It then draws an unbiased final face from the free-running random source by rejection sampling. The result is held in binary and 2-digit BCD for the seven-segment display driver. It sits between the board inputs (ui_in) and the random-number/display datapath.

---
 rtl/dice_roll_sequencer_if.sv | 25 ++
 rtl/dice_roll_sequencer.sv | 151 +++++++++++++++
 tb/tb_dice_roll_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dice_roll_sequencer_if.sv
// Board-side bundle of the dice roller: button/die/random inputs and result/status outputs.
// The slave side is the sequencer; the master side drives the inputs.
interface dice_roll_sequencer_if #(
  parameter int RND_W = 8
) ();
  logic             roll_btn;
  logic [2:0]       die_sel;
  logic [RND_W-1:0] rnd_in;
  logic [4:0]       value;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;
  logic             busy;
  logic             result_valid;
  logic             done_pulse;

  modport master (
    output roll_btn, die_sel, rnd_in,
    input  value, bcd_tens, bcd_ones, busy, result_valid, done_pulse
  );

  modport slave (
    input  roll_btn, die_sel, rnd_in,
    output value, bcd_tens, bcd_ones, busy, result_valid, done_pulse
  );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Die-roll controller: debounces the button, animates for a fixed number of ticks,
// then draws an unbiased face by rejection sampling and holds it in binary and BCD.
module dice_roll_sequencer #(
  parameter int RND_W      = 8,
  parameter int TICK_DIV   = 2500000,
  parameter int ROLL_STEPS = 12,
  parameter int DEBOUNCE   = 50000,
  parameter int MAX_REJECT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dice_roll_sequencer_if.slave  bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = $clog2(ROLL_STEPS + 1);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int REJ_W  = $clog2(MAX_REJECT + 1);

  typedef enum logic [1:0] {IDLE, ROLL, DRAW, SHOW} state_t;

  function automatic logic [9:0] die_decode(input logic [2:0] sel);
    case (sel)
      3'd0:    return {5'd4,  5'd3};
      3'd1:    return {5'd6,  5'd7};
      3'd2:    return {5'd8,  5'd7};
      3'd3:    return {5'd10, 5'd15};
      3'd4:    return {5'd12, 5'd15};
      default: return {5'd20, 5'd31};
    endcase
  endfunction

  // r < 2N always holds after masking, so one subtraction folds any sample into 1..N.
  function automatic logic [4:0] fold_face(input logic [4:0] r, input logic [4:0] n);
    return (r < n) ? r + 5'd1 : r - n + 5'd1;
  endfunction

  function automatic logic [3:0] tens_of(input logic [4:0] v);
    return (v >= 5'd20) ? 4'd2 : (v >= 5'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [4:0] v);
    return (v >= 5'd20) ? 4'(v - 5'd20) : (v >= 5'd10) ? 4'(v - 5'd10) : 4'(v);
  endfunction

  logic            btn_sync_p0, btn_sync_p1, btn_db, press_p2;
  logic [DB_W-1:0] db_cnt;

  state_t           state;
  logic [4:0]       n_q, mask_q, r, face;
  logic [TICK_W-1:0] tick_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [REJ_W-1:0]  rej_cnt;
  logic             tick_wrap, draw_done, load_face;

  // Stage p0/p1: synchronizer; stage p2: stability filter and press event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      btn_db      <= 1'b0;
      db_cnt      <= '0;
      press_p2    <= 1'b0;
    end else begin
      btn_sync_p0 <= bus.roll_btn;
      btn_sync_p1 <= btn_sync_p0;
      press_p2    <= 1'b0;
      if (btn_sync_p1 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        btn_db   <= btn_sync_p1;
        db_cnt   <= '0;
        press_p2 <= btn_sync_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign r         = bus.rnd_in[4:0] & mask_q;
  assign face      = fold_face(r, n_q);
  assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
  // An accepted sample folds to r+1 as well, so DRAW always loads the folded face.
  assign draw_done = (r < n_q) || (rej_cnt == REJ_W'(MAX_REJECT - 1));
  assign load_face = ((state == ROLL) && tick_wrap) || ((state == DRAW) && draw_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      n_q              <= '0;
      mask_q           <= '0;
      tick_cnt         <= '0;
      step_cnt         <= '0;
      rej_cnt          <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.done_pulse   <= 1'b0;
    end else begin
      bus.done_pulse <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (press_p2) begin
            {n_q, mask_q}    <= die_decode(bus.die_sel);
            tick_cnt         <= '0;
            step_cnt         <= '0;
            rej_cnt          <= '0;
            bus.busy         <= 1'b1;
            bus.result_valid <= 1'b0;
            state            <= ROLL;
          end
        end
        ROLL: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            step_cnt <= step_cnt + 1'b1;
            if (step_cnt == STEP_W'(ROLL_STEPS - 1)) begin
              rej_cnt <= '0;
              state   <= DRAW;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DRAW: begin
          if (draw_done) begin
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
            bus.done_pulse   <= 1'b1;
            state            <= SHOW;
          end else begin
            rej_cnt <= rej_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.value    <= '0;
      bus.bcd_tens <= '0;
      bus.bcd_ones <= '0;
    end else if (load_face) begin
      bus.value    <= face;
      bus.bcd_tens <= tens_of(face);
      bus.bcd_ones <= ones_of(face);
    end
  end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Scoreboard bench for dice_roll_sequencer: rolls push their expected face into a queue,
// and a monitor pops and compares whenever done_pulse is presented.
module tb_dice_roll_sequencer;
  localparam int RND_W      = 8;
  localparam int TICK_DIV   = 4;
  localparam int ROLL_STEPS = 3;
  localparam int DEBOUNCE   = 2;
  localparam int MAX_REJECT = 8;
  localparam int ROLL_CYC   = TICK_DIV * ROLL_STEPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dice_roll_sequencer_if #(.RND_W(RND_W)) bus ();

  dice_roll_sequencer #(
    .RND_W(RND_W), .TICK_DIV(TICK_DIV), .ROLL_STEPS(ROLL_STEPS),
    .DEBOUNCE(DEBOUNCE), .MAX_REJECT(MAX_REJECT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int n_tab[8]    = '{4, 6, 8, 10, 12, 20, 20, 20};
  int mask_tab[8] = '{3, 7, 7, 15, 15, 31, 31, 31};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sample_of(input int rnd, input int sel);
    return (rnd % 32) & mask_tab[sel];
  endfunction

  function automatic int fold_of(input int rnd, input int sel);
    int s;
    s = sample_of(rnd, sel);
    return (s < n_tab[sel]) ? s + 1 : s - n_tab[sel] + 1;
  endfunction

  // Monitor: every done_pulse must match the oldest outstanding roll
  int mon_e;
  always @(negedge clk) begin
    if (rst_n && bus.done_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("value", bus.value, mon_e);
        check("bcd_tens", bus.bcd_tens, mon_e / 10);
        check("bcd_ones", bus.bcd_ones, mon_e % 10);
        check("valid_with_done", bus.result_valid, 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_roll(input int sel);
    int k;
    bus.die_sel  = 3'(sel);
    bus.roll_btn = 1'b1;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.busy) break;
    end
    check("press_to_busy", k, 2 + DEBOUNCE + 1);
  endtask

  // Called on the first busy cycle; runs ROLL and DRAW, then checks the SHOW entry.
  task automatic run_roll(input int sel, input int seq[8], input int roll_rnd,
                          input bit mid_press, input int new_sel);
    int i, acc, exp_v, exp_busy;
    int hist[64];
    acc = -1;
    for (int k = 0; k < MAX_REJECT; k++)
      if (acc < 0 && sample_of(seq[k], sel) < n_tab[sel]) acc = k;
    exp_v    = (acc >= 0) ? sample_of(seq[acc], sel) + 1 : fold_of(seq[MAX_REJECT-1], sel);
    exp_busy = ROLL_CYC + ((acc >= 0) ? acc + 1 : MAX_REJECT);
    exp_q.push_back(exp_v);
    bus.roll_btn = 1'b0;
    i = 0;
    while (bus.busy && i < 60) begin
      if (i >= TICK_DIV && i <= ROLL_CYC)
        check("tick_value", bus.value, fold_of(hist[(i / TICK_DIV) * TICK_DIV - 1], sel));
      if (i >= ROLL_CYC && i - ROLL_CYC < MAX_REJECT)
        bus.rnd_in = 8'(seq[i - ROLL_CYC]);
      else if (roll_rnd >= 0)
        bus.rnd_in = 8'(roll_rnd);
      else
        bus.rnd_in = 8'($urandom);
      hist[i] = int'(bus.rnd_in);
      if (mid_press) begin
        if (i == 2) bus.die_sel = 3'(new_sel);
        if (i == 3) bus.roll_btn = 1'b1;
        if (i == 9) bus.roll_btn = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    check("busy_cycles", i, exp_busy);
    check("valid_at_show", bus.result_valid, 1);
    @(negedge clk);
    check("done_one_cycle", bus.done_pulse, 0);
    check("valid_held", bus.result_valid, 1);
    check("value_held", bus.value, exp_v);
    check("busy_in_show", bus.busy, 0);
  endtask

  initial begin
    int seq[8];
    int k, sel;
    bus.roll_btn = 1'b1;
    bus.die_sel  = 3'd1;
    bus.rnd_in   = 8'h03;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state with the button held high
    check("rst_value", bus.value, 0);
    check("rst_tens", bus.bcd_tens, 0);
    check("rst_ones", bus.bcd_ones, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_done", bus.done_pulse, 0);

    // Held button needs the full sync + debounce path after release
    rst_n = 1'b1;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.busy) break;
    end
    check("release_to_busy", k, 2 + DEBOUNCE + 1);
    foreach (seq[j]) seq[j] = 8'h03;
    run_roll(1, seq, 8'h03, 1'b0, 0);

    // d20 with an always-rejected sample; d7 selection decodes the same
    foreach (seq[j]) seq[j] = 8'h1F;
    start_roll(5);
    run_roll(5, seq, -1, 1'b0, 0);
    start_roll(7);
    run_roll(7, seq, -1, 1'b0, 0);

    // Press and die change during ROLL are ignored; a press in SHOW re-latches
    foreach (seq[j]) seq[j] = 8'h09;
    start_roll(1);
    run_roll(1, seq, -1, 1'b1, 5);
    start_roll(5);
    run_roll(5, seq, -1, 1'b0, 0);

    // Asynchronous reset mid-ROLL
    start_roll(1);
    bus.roll_btn = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_value", bus.value, 0);
    check("async_tens", bus.bcd_tens, 0);
    check("async_ones", bus.bcd_ones, 0);
    check("async_busy", bus.busy, 0);
    check("async_valid", bus.result_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Bouncing button never settles: no roll starts
    for (int c = 0; c < 30; c++) begin
      bus.roll_btn = (c < 20) ? 1'(c % 2) : 1'b0;
      @(negedge clk);
      check("bounce_busy", bus.busy, 0);
      check("bounce_valid", bus.result_valid, 0);
    end

    // Randomized rolls
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 7);
      foreach (seq[j]) seq[j] = ($urandom_range(0, 3) == 0) ? 8'h1F : int'($urandom_range(0, 255));
      start_roll(sel);
      run_roll(sel, seq, -1, ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
